// File: rtl/packet_receiver.sv
// packet_receiver: four-phase channel receiver that frames packets by header bit,
// buffers accepted flits in a small FIFO and keeps saturating packet/error counters.
`default_nettype none

module packet_receiver #(
   parameter int ID       = 0,
   parameter int SIZE     = 8,
   parameter int FLITS    = 8,
   parameter int DEPTH    = 4,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ch_req,
   input  logic [SIZE-1:0]     ch_data,
   output logic                ch_ack,
   output logic                out_valid,
   output logic [SIZE-1:0]     out_data,
   output logic                out_last,
   input  logic                out_ready,
   output logic [CNT_BITS-1:0] pkt_count,
   output logic [CNT_BITS-1:0] err_count,
   output logic                busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int IW = (FLITS > 1) ? $clog2(FLITS) : 1;
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
   localparam logic [IW-1:0] C_TAIL = IW'(FLITS - 1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FLITS < 2) begin : g_bad_params
      $error("packet_receiver %0d: DEPTH must be a power of two >= 2 and FLITS >= 2", ID);
   end

   typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

   state_t              r_state;
   logic                r_ack;
   logic [IW-1:0]       r_idx;
   logic [CNT_BITS-1:0] r_pkt;
   logic [CNT_BITS-1:0] r_err;
   logic [SIZE:0]       r_mem [DEPTH];
   logic [AW-1:0]       r_wptr;
   logic [AW-1:0]       r_rptr;
   logic [CW-1:0]       r_count;

   logic          w_pop;
   logic          w_space;
   logic          w_take;
   logic          w_hdr;
   logic          w_first;
   logic          w_tail;
   logic          w_push;
   logic          w_last;
   logic          w_err_inc;
   logic          w_pkt_inc;
   logic [SIZE:0] w_head;

   assign w_pop   = (r_count != '0) && out_ready;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign w_space = (r_count != C_FULL) || w_pop;
   assign w_take  = (r_state == S_IDLE) && ch_req && w_space;
   assign w_hdr   = ch_data[SIZE-1];
   assign w_first = (r_idx == '0);
   assign w_tail  = (r_idx == C_TAIL);

   assign w_push    = w_take && (w_hdr || !w_first);
   assign w_last    = !w_hdr && w_tail;
   assign w_err_inc = w_take && (w_hdr ? !w_first : w_first);
   assign w_pkt_inc = w_take && !w_hdr && w_tail;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_ack   <= 1'b0;
         r_idx   <= '0;
         r_pkt   <= '0;
         r_err   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_take) begin
                  r_state <= S_ACK;
                  r_ack   <= 1'b1;
               end
            end
            S_ACK: begin
               if (!ch_req) begin
                  r_state <= S_IDLE;
                  r_ack   <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ack   <= 1'b0;
            end
         endcase

         // A header always restarts framing; a stray body at index 0 is dropped.
         if (w_take) begin
            if (w_hdr)
               r_idx <= IW'(1);
            else if (!w_first)
               r_idx <= w_tail ? '0 : r_idx + IW'(1);
         end

         if (w_pkt_inc && r_pkt != '1)
            r_pkt <= r_pkt + CNT_BITS'(1);
         if (w_err_inc && r_err != '1)
            r_err <= r_err + CNT_BITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= {w_last, ch_data};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + AW'(1);
         if (w_pop)
            r_rptr <= r_rptr + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head    = r_mem[r_rptr];
   assign out_valid = (r_count != '0);
   assign out_data  = out_valid ? w_head[SIZE-1:0] : '0;
   assign out_last  = out_valid & w_head[SIZE];
   assign ch_ack    = r_ack;
   assign pkt_count = r_pkt;
   assign err_count = r_err;
   assign busy      = (r_idx != '0);

endmodule

`default_nettype wire

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver: scoreboard bench with a framing model; a second instance
// with 2-bit counters shares the channel to exercise saturation.
`default_nettype none

module tb_packet_receiver;

   localparam int SIZE  = 8;
   localparam int FLITS = 8;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ch_req = 1'b0;
   logic [7:0] ch_data = 8'h00;
   logic       out_ready = 1'b1;
   logic       one = 1'b1;

   logic        ch_ack, out_valid, out_last, busy;
   logic [7:0]  out_data;
   logic [15:0] pkt_count, err_count;

   logic        ch_ack2, out_valid2, out_last2, busy2;
   logic [7:0]  out_data2;
   logic [1:0]  pkt_count2, err_count2;

   packet_receiver #(.ID(0), .SIZE(SIZE), .FLITS(FLITS), .DEPTH(DEPTH), .CNT_BITS(16)) dut (
      .clk(clk), .reset(reset), .ch_req(ch_req), .ch_data(ch_data), .ch_ack(ch_ack),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .pkt_count(pkt_count), .err_count(err_count), .busy(busy));

   packet_receiver #(.ID(1), .SIZE(SIZE), .FLITS(FLITS), .DEPTH(DEPTH), .CNT_BITS(2)) dut2 (
      .clk(clk), .reset(reset), .ch_req(ch_req), .ch_data(ch_data), .ch_ack(ch_ack2),
      .out_valid(out_valid2), .out_data(out_data2), .out_last(out_last2), .out_ready(one),
      .pkt_count(pkt_count2), .err_count(err_count2), .busy(busy2));

   always #5 clk = ~clk;

   int         total = 0;
   int         bad = 0;
   logic [8:0] exp_q[$];
   logic [8:0] mon_e;
   int         m_idx = 0;
   int         m_pkt = 0;
   int         m_err = 0;
   int         n_out = 0;
   bit         rand_ready = 1'b0;

   function automatic int cap(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic flag_fail(string nm);
      total++;
      bad++;
      $display("FAIL %s: bound expired", nm);
   endtask

   // Packet framing rules: header starts a packet, FLITS-th flit ends it.
   task automatic model_flit(logic [7:0] d);
      if (d[7]) begin
         if (m_idx != 0) m_err++;
         exp_q.push_back({1'b0, d});
         m_idx = 1;
      end else if (m_idx == 0) begin
         m_err++;
      end else if (m_idx == FLITS - 1) begin
         exp_q.push_back({1'b1, d});
         m_pkt++;
         m_idx = 0;
      end else begin
         exp_q.push_back({1'b0, d});
         m_idx++;
      end
   endtask

   task automatic wait_ack(logic lvl, int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(posedge clk); #1;
         if (ch_ack === lvl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic send(logic [7:0] d);
      bit ok;
      ch_data = d;
      ch_req  = 1'b1;
      model_flit(d);
      wait_ack(1'b1, 300, ok);
      if (!ok) flag_fail("ack_rise");
      ch_req = 1'b0;
      wait_ack(1'b0, 10, ok);
      if (!ok) flag_fail("ack_fall");
   endtask

   task automatic send_good(logic [6:0] dst);
      send({1'b1, dst});
      for (int i = 1; i < FLITS; i++) send(8'(i));
   endtask

   task automatic drain(string nm);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!done) flag_fail(nm);
   endtask

   task automatic check_state(string tag);
      chk({tag, "_pkt"}, pkt_count, cap(m_pkt, 65535));
      chk({tag, "_err"}, err_count, cap(m_err, 65535));
      chk({tag, "_busy"}, busy, (m_idx != 0) ? 1 : 0);
      chk({tag, "_pkt_sat"}, pkt_count2, cap(m_pkt, 3));
      chk({tag, "_err_sat"}, err_count2, cap(m_err, 3));
   endtask

   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            flag_fail("unexpected_out");
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_flit", {out_last, out_data}, mon_e);
            n_out++;
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      logic [7:0] d;
      bit hdr;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", ch_ack, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
      chk("rst_pkt", pkt_count, 0);
      chk("rst_err", err_count, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // One clean packet with a free-flowing consumer.
      n_out = 0;
      send_good(7'h01);
      drain("drain_basic");
      chk("basic_nout", n_out, 8);
      check_state("basic");

      // Stalled consumer: four flits fit, the fifth request must wait.
      out_ready = 1'b0;
      n_out = 0;
      send(8'h81);
      for (int i = 1; i < 4; i++) send(8'(i));
      ch_data = 8'h04;
      ch_req  = 1'b1;
      model_flit(8'h04);
      repeat (10) @(posedge clk);
      #1;
      chk("stall_ack", ch_ack, 0);
      chk("stall_valid", out_valid, 1);
      out_ready = 1'b1;
      wait_ack(1'b1, 20, ok);
      if (!ok) flag_fail("stall_release");
      ch_req = 1'b0;
      wait_ack(1'b0, 10, ok);
      if (!ok) flag_fail("stall_ack_fall");
      for (int i = 5; i < FLITS; i++) send(8'(i));
      drain("drain_stall");
      chk("stall_nout", n_out, 8);
      check_state("stall");

      // Body flit with no header in progress is dropped.
      n_out = 0;
      send(8'h05);
      repeat (3) @(posedge clk);
      #1;
      chk("orphan_nout", n_out, 0);
      chk("orphan_valid", out_valid, 0);
      check_state("orphan");

      // Header arriving mid-packet aborts and restarts.
      n_out = 0;
      send(8'h81);
      send(8'h01);
      send(8'h82);
      for (int i = 3; i < 10; i++) send(8'(i));
      drain("drain_abort");
      chk("abort_nout", n_out, 10);
      check_state("abort");

      // Reset between ack rise and request fall.
      send(8'h81);
      ch_data = 8'h01;
      ch_req  = 1'b1;
      model_flit(8'h01);
      wait_ack(1'b1, 20, ok);
      if (!ok) flag_fail("midrst_ack");
      reset = 1'b0;
      #1;
      chk("midrst_ack0", ch_ack, 0);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_data", out_data, 0);
      chk("midrst_last", out_last, 0);
      chk("midrst_pkt", pkt_count, 0);
      chk("midrst_err", err_count, 0);
      chk("midrst_busy", busy, 0);
      exp_q.delete();
      m_idx = 0;
      m_pkt = 0;
      m_err = 0;
      ch_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      n_out = 0;
      send_good(7'h03);
      drain("drain_postrst");
      chk("postrst_nout", n_out, 8);
      check_state("postrst");

      // Five more good packets push the narrow counters to saturation.
      for (int p = 0; p < 5; p++) send_good(7'(p + 10));
      drain("drain_sat");
      check_state("sat");

      // Randomized packets with occasional header-bit corruption and a jittery consumer.
      rand_ready = 1'b1;
      for (int p = 0; p < 40; p++) begin
         for (int i = 0; i < FLITS; i++) begin
            hdr = (i == 0);
            if ($urandom_range(0, 11) == 0) hdr = ~hdr;
            d = {hdr, 7'($urandom)};
            send(d);
         end
      end
      rand_ready = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain("drain_rand");
      check_state("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
